// File: rtl/dt_chamfer_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dt_chamfer_param
// Purpose  : Two-pass chamfer distance transform (chessboard / city-block)
// Revision : 1.0
// ============================================================================
module dt_chamfer_param #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ROM_DW = 16,
  parameter int PIX_W  = 8,
  localparam int SA_W  = $clog2(IMG_W*IMG_H/ROM_DW),
  localparam int RA_W  = $clog2(IMG_W*IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              sti_rd,
  output logic [SA_W-1:0]   sti_addr,
  input  logic [ROM_DW-1:0] sti_di,
  output logic              res_rd,
  output logic              res_wr,
  output logic [RA_W-1:0]   res_addr,
  output logic [PIX_W-1:0]  res_do,
  input  logic [PIX_W-1:0]  res_di
);
  localparam int c_NWORDS = IMG_W*IMG_H/ROM_DW;
  localparam int c_CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int c_BW     = (ROM_DW > 1) ? $clog2(ROM_DW) : 1;
  localparam logic [PIX_W-1:0] c_MAXD      = '1;
  localparam logic [c_CW-1:0]  c_COL_LAST  = c_CW'(IMG_W-1);
  localparam logic [c_RW-1:0]  c_ROW_LAST  = c_RW'(IMG_H-1);
  localparam logic [c_BW-1:0]  c_BIT_LAST  = c_BW'(ROM_DW-1);
  localparam logic [SA_W-1:0]  c_WORD_LAST = SA_W'(c_NWORDS-1);
  localparam logic [RA_W-1:0]  c_W_RA      = RA_W'(IMG_W);
  localparam logic [RA_W-1:0]  c_DW_RA     = RA_W'(ROM_DW);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,  S_LOAD_RD = 4'd1,  S_LOAD_WR = 4'd2,
    S_FW_CHK  = 4'd3,  S_FW_EVAL = 4'd4,  S_FW_NB   = 4'd5,  S_FW_WR = 4'd6,
    S_BW_CHK  = 4'd7,  S_BW_EVAL = 4'd8,  S_BW_NB   = 4'd9,  S_BW_WR = 4'd10,
    S_DONE    = 4'd11
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_mode, w_mode_nxt;
  logic [SA_W-1:0]   r_widx, w_widx_nxt;
  logic [c_BW-1:0]   r_bit, w_bit_nxt;
  logic [ROM_DW-1:0] r_word, w_word_nxt;
  logic [c_RW-1:0]   r_row, w_row_nxt, w_step_row;
  logic [c_CW-1:0]   r_col, w_col_nxt, w_step_col;
  logic [2:0]        r_nb, w_nb_nxt, w_iss, w_k;
  logic              r_nb_ok, w_nb_ok_nxt;
  logic [PIX_W-1:0]  r_ctr, w_ctr_nxt, r_min, w_min_nxt;
  logic              r_busy, r_done;

  logic              w_accept, w_back, w_pass_end;
  logic              w_up, w_lf, w_rt, w_n, w_s, w_w, w_e, w_nb_ok;
  logic [RA_W-1:0]   w_ctr_addr, w_nb_addr, w_load_addr;
  logic [PIX_W-1:0]  w_nb_val, w_min_cap, w_inc, w_bw_val;
  logic [ROM_DW-1:0] w_word;

  assign busy     = r_busy;
  assign done     = r_done;
  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_back   = (r_state == S_BW_CHK) || (r_state == S_BW_EVAL) ||
                    (r_state == S_BW_NB)  || (r_state == S_BW_WR);
  assign w_k      = r_mode ? 3'd2 : 3'd4;
  assign w_iss    = (r_state == S_FW_EVAL || r_state == S_BW_EVAL) ? 3'd0 : r_nb;

  // The ROM word is only guaranteed in the first write cycle; later bits come from the copy.
  assign w_word      = (r_bit == '0) ? sti_di : r_word;
  assign w_load_addr = RA_W'(r_widx) * c_DW_RA + RA_W'(r_bit);
  assign w_ctr_addr  = RA_W'(r_row) * c_W_RA + RA_W'(r_col);

  // Forward neighbour table; the backward pass mirrors it through the centre.
  always_comb begin
    w_up = 1'b0;
    w_lf = 1'b0;
    w_rt = 1'b0;
    if (r_mode) begin
      w_up = (w_iss == 3'd0);
      w_lf = (w_iss == 3'd1);
    end else begin
      case (w_iss)
        3'd0:    begin w_up = 1'b1; w_lf = 1'b1; end
        3'd1:    w_up = 1'b1;
        3'd2:    begin w_up = 1'b1; w_rt = 1'b1; end
        default: w_lf = 1'b1;
      endcase
    end
  end

  assign w_n       = w_up & ~w_back;
  assign w_s       = w_up & w_back;
  assign w_w       = w_back ? w_rt : w_lf;
  assign w_e       = w_back ? w_lf : w_rt;
  assign w_nb_ok   = !(w_n && r_row == '0) && !(w_s && r_row == c_ROW_LAST) &&
                     !(w_w && r_col == '0) && !(w_e && r_col == c_COL_LAST);
  assign w_nb_addr = w_ctr_addr + (w_n ? -c_W_RA : (w_s ? c_W_RA : '0))
                                + (w_w ? '1 : (w_e ? RA_W'(1) : '0));
  assign w_nb_val  = r_nb_ok ? res_di : '0;
  assign w_min_cap = (w_nb_val < r_min) ? w_nb_val : r_min;
  assign w_inc     = (r_min == c_MAXD) ? c_MAXD : r_min + 1'b1;
  assign w_bw_val  = (r_ctr < w_inc) ? r_ctr : w_inc;

  always_comb begin
    w_step_row = r_row;
    w_step_col = r_col;
    w_pass_end = 1'b0;
    if (w_back) begin
      w_pass_end = (r_row == '0) && (r_col == '0);
      if (r_col == '0) begin
        w_step_col = c_COL_LAST;
        w_step_row = r_row - 1'b1;
      end else begin
        w_step_col = r_col - 1'b1;
      end
    end else begin
      w_pass_end = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
      if (r_col == c_COL_LAST) begin
        w_step_col = '0;
        w_step_row = r_row + 1'b1;
      end else begin
        w_step_col = r_col + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_widx_nxt  = r_widx;
    w_bit_nxt   = r_bit;
    w_word_nxt  = r_word;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_nb_nxt    = r_nb;
    w_nb_ok_nxt = r_nb_ok;
    w_ctr_nxt   = r_ctr;
    w_min_nxt   = r_min;
    sti_rd      = 1'b0;
    sti_addr    = '0;
    res_rd      = 1'b0;
    res_wr      = 1'b0;
    res_addr    = '0;
    res_do      = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = S_LOAD_RD;
          w_mode_nxt  = mode;
          w_widx_nxt  = '0;
        end
      end
      S_LOAD_RD: begin
        sti_rd      = 1'b1;
        sti_addr    = r_widx;
        w_bit_nxt   = '0;
        w_state_nxt = S_LOAD_WR;
      end
      S_LOAD_WR: begin
        res_wr     = 1'b1;
        res_addr   = w_load_addr;
        res_do     = PIX_W'(w_word[c_BIT_LAST - r_bit]);
        w_word_nxt = w_word;
        if (r_bit == c_BIT_LAST) begin
          if (r_widx == c_WORD_LAST) begin
            w_state_nxt = S_FW_CHK;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
          end else begin
            w_widx_nxt  = r_widx + 1'b1;
            w_state_nxt = S_LOAD_RD;
          end
        end else begin
          w_bit_nxt = r_bit + 1'b1;
        end
      end
      S_FW_CHK, S_BW_CHK: begin
        res_rd      = 1'b1;
        res_addr    = w_ctr_addr;
        w_state_nxt = w_back ? S_BW_EVAL : S_FW_EVAL;
      end
      S_FW_EVAL, S_BW_EVAL: begin
        if (res_di == '0) begin
          if (w_pass_end) begin
            w_state_nxt = w_back ? S_DONE : S_BW_CHK;
          end else begin
            w_state_nxt = w_back ? S_BW_CHK : S_FW_CHK;
            w_row_nxt   = w_step_row;
            w_col_nxt   = w_step_col;
          end
        end else begin
          w_ctr_nxt   = res_di;
          w_min_nxt   = c_MAXD;
          res_rd      = w_nb_ok;
          res_addr    = w_nb_ok ? w_nb_addr : '0;
          w_nb_ok_nxt = w_nb_ok;
          w_nb_nxt    = 3'd1;
          w_state_nxt = w_back ? S_BW_NB : S_FW_NB;
        end
      end
      S_FW_NB, S_BW_NB: begin
        w_min_nxt = w_min_cap;
        if (r_nb == w_k) begin
          w_state_nxt = w_back ? S_BW_WR : S_FW_WR;
        end else begin
          res_rd      = w_nb_ok;
          res_addr    = w_nb_ok ? w_nb_addr : '0;
          w_nb_ok_nxt = w_nb_ok;
          w_nb_nxt    = r_nb + 1'b1;
        end
      end
      S_FW_WR, S_BW_WR: begin
        res_wr   = 1'b1;
        res_addr = w_ctr_addr;
        res_do   = w_back ? w_bw_val : w_inc;
        if (w_pass_end) begin
          w_state_nxt = w_back ? S_DONE : S_BW_CHK;
        end else begin
          w_state_nxt = w_back ? S_BW_CHK : S_FW_CHK;
          w_row_nxt   = w_step_row;
          w_col_nxt   = w_step_col;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_widx  <= '0;
      r_bit   <= '0;
      r_word  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_nb    <= '0;
      r_nb_ok <= 1'b0;
      r_ctr   <= '0;
      r_min   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_widx  <= w_widx_nxt;
      r_bit   <= w_bit_nxt;
      r_word  <= w_word_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_nb    <= w_nb_nxt;
      r_nb_ok <= w_nb_ok_nxt;
      r_ctr   <= w_ctr_nxt;
      r_min   <= w_min_nxt;
      // done follows the DONE state by one cycle, closing the run budget.
      if (w_accept) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_dt_chamfer_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dt_chamfer_param
// Purpose  : Random and directed images against a two-pass reference model
// Revision : 1.0
// ============================================================================
module tb_dt_chamfer_param;
  localparam int W      = 16;
  localparam int H      = 16;
  localparam int DW     = 8;
  localparam int PW     = 3;
  localparam int NPIX   = W*H;
  localparam int NWORDS = NPIX/DW;
  localparam int SA     = $clog2(NWORDS);
  localparam int RA     = $clog2(NPIX);
  localparam int MAXD   = (1 << PW) - 1;

  typedef struct { int addr; int data; } wr_t;

  logic          clk = 1'b0;
  logic          reset, start, mode;
  logic          busy, done, sti_rd, res_rd, res_wr;
  logic [SA-1:0] sti_addr;
  logic [DW-1:0] sti_di;
  logic [RA-1:0] res_addr;
  logic [PW-1:0] res_do, res_di;

  logic [DW-1:0] rom [NWORDS];
  logic [PW-1:0] ram [NPIX];
  int            expd [H][W];
  wr_t           expq [$];
  int            exp_cyc;
  int            n_tests, n_fail;
  bit            mon_en;

  dt_chamfer_param #(.IMG_W(W), .IMG_H(H), .ROM_DW(DW), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .busy(busy), .done(done),
    .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do), .res_di(res_di)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sti_rd) sti_di <= rom[sti_addr];
    if (res_wr) ram[res_addr] <= res_do;
    if (res_rd) res_di <= ram[res_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int val(int r, int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 0;
    return expd[r][c];
  endfunction

  function automatic int inc(int x);
    return (x == MAXD) ? MAXD : x + 1;
  endfunction

  // Whole-image reference: expected final image, write stream and cycle count.
  task automatic model(input bit m);
    int  dr[4], dc[4];
    int  k, nobj, mn, v, b;
    wr_t e;
    k = m ? 2 : 4;
    if (m) begin dr = '{-1, 0, 0, 0}; dc = '{0, -1, 0, 0}; end
    else   begin dr = '{-1, -1, -1, 0}; dc = '{-1, 0, 1, -1}; end
    expq.delete();
    nobj = 0;
    for (int a = 0; a < NPIX; a++) begin
      b = int'(rom[a/DW][DW-1-(a%DW)]);
      expd[a/W][a%W] = b;
      nobj += b;
      e.addr = a; e.data = b; expq.push_back(e);
    end
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (expd[r][c] != 0) begin
          mn = MAXD;
          for (int j = 0; j < k; j++) begin v = val(r+dr[j], c+dc[j]); if (v < mn) mn = v; end
          expd[r][c] = inc(mn);
          e.addr = r*W+c; e.data = expd[r][c]; expq.push_back(e);
        end
    for (int r = H-1; r >= 0; r--)
      for (int c = W-1; c >= 0; c--)
        if (expd[r][c] != 0) begin
          mn = MAXD;
          for (int j = 0; j < k; j++) begin v = val(r-dr[j], c-dc[j]); if (v < mn) mn = v; end
          if (inc(mn) < expd[r][c]) expd[r][c] = inc(mn);
          e.addr = r*W+c; e.data = expd[r][c]; expq.push_back(e);
        end
    exp_cyc = NWORDS*(DW+1) + 2*((NPIX-nobj)*2 + nobj*(k+3)) + 1;
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sti_rd || res_rd || res_wr)
          check("strobe_onehot", 32'(sti_rd) + 32'(res_rd) + 32'(res_wr), 32'd1);
        if (sti_rd) check("sti_addr_range", 32'(32'(sti_addr) < NWORDS), 32'd1);
        if (mon_en && res_wr) begin
          if (expq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL extra_write: addr %0d data %0d, no write expected", res_addr, res_do);
          end else begin
            e = expq.pop_front();
            check("write_addr", 32'(res_addr), 32'(e.addr));
            check("write_data", 32'(res_do), 32'(e.data));
          end
        end
      end
    end
  endtask

  task automatic check_ram(input string nm);
    int bad, first;
    bad = 0; first = -1;
    for (int a = 0; a < NPIX; a++)
      if (ram[a] !== PW'(expd[a/W][a%W])) begin bad++; if (first < 0) first = a; end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_ram: %0d pixels differ, first addr %0d got %0d expected %0d",
               nm, bad, first, ram[first], expd[first/W][first%W]);
    end
  endtask

  task automatic run(input bit m, input bit poke, input string nm);
    int n;
    bit got, busy_bad;
    model(m);
    @(negedge clk);
    start = 1'b1; mode = m; mon_en = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mode = ~m;
    n = 0; got = 0; busy_bad = 0;
    while (!got && n < exp_cyc + 50) begin
      @(posedge clk);
      n++;
      #1;
      if (done) got = 1;
      else if (!busy) busy_bad = 1;
      start = poke && (n % 97 == 5) && (n < exp_cyc - 3);
    end
    start = 1'b0;
    check({nm, "_done_cycle"}, got ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_cyc));
    check({nm, "_busy_held"}, 32'(busy_bad), 32'd0);
    check({nm, "_busy_after"}, 32'(busy), 32'd0);
    check({nm, "_writes_left"}, 32'(expq.size()), 32'd0);
    check_ram(nm);
    mon_en = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < NWORDS; i++) rom[i] = '0;
  endtask

  task automatic set_pix(input int r, input int c);
    int a;
    a = r*W + c;
    rom[a/DW][DW-1-(a%DW)] = 1'b1;
  endtask

  task automatic rand_img(input bit dense);
    for (int i = 0; i < NWORDS; i++)
      rom[i] = dense ? (DW'($urandom) | DW'($urandom)) : DW'($urandom);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; mon_en = 1'b0;
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({busy, done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do}), 32'd0);
    reset = 1'b0;

    clear_rom();
    run(1'b0, 1'b0, "zero");
    check("zero_cycles_literal", 32'(exp_cyc), 32'd1313);

    clear_rom(); set_pix(8, 8);
    run(1'b0, 1'b0, "single");
    check("single_model", 32'(expd[8][8]), 32'd1);
    check("single_ram", 32'(ram[8*W+8]), 32'd1);
    check("single_nb_ram", 32'(ram[7*W+8]), 32'd0);

    clear_rom();
    for (int r = 6; r <= 10; r++) for (int c = 6; c <= 10; c++) set_pix(r, c);
    run(1'b0, 1'b0, "block_m0");
    check("block_m0_centre_model", 32'(expd[8][8]), 32'd3);
    check("block_m0_centre_ram", 32'(ram[8*W+8]), 32'd3);
    check("block_m0_ring_ram", 32'(ram[7*W+7]), 32'd2);
    check("block_m0_outer_ram", 32'(ram[6*W+6]), 32'd1);
    run(1'b1, 1'b0, "block_m1");
    check("block_m1_centre_ram", 32'(ram[8*W+8]), 32'd3);
    check("block_m1_left_ram", 32'(ram[8*W+7]), 32'd2);
    check("block_m1_corner_ram", 32'(ram[6*W+6]), 32'd1);
    check("block_m1_edge_ram", 32'(ram[6*W+8]), 32'd1);

    for (int i = 0; i < NWORDS; i++) rom[i] = '1;
    run(1'b0, 1'b0, "ones");
    check("ones_sat_model", 32'(expd[8][8]), 32'(MAXD));
    check("ones_sat_ram", 32'(ram[8*W+8]), 32'(MAXD));
    check("ones_corner_ram", 32'(ram[0]), 32'd1);
    check("ones_diag_ram", 32'(ram[W+1]), 32'd2);

    for (int i = 0; i < 4; i++) begin
      rand_img(i < 2);
      run(1'(i % 2), 1'b0, "random");
    end

    rand_img(1'b1);
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (NWORDS*(DW+1) + 40) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("async_reset_outputs", 32'({busy, done, sti_rd, res_rd, res_wr}), 32'd0);
    @(negedge clk);
    check("held_reset_outputs", 32'({busy, done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do}), 32'd0);
    reset = 1'b0;
    run(1'b1, 1'b1, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dt_chamfer_param.md
# dt_chamfer_param

Parametrised two-pass chamfer distance-transform engine. It reads a packed binary image from the stimulus ROM, expands it into the result RAM, then runs a forward and a backward raster pass in place. After the run, every object pixel holds its distance to the nearest background pixel. It generalises the fixed 128x128, 8-neighbour engine to arbitrary image size, ROM word width and distance width, and adds a run-time selectable 4-neighbour (city-block) metric.

## Interface
- IMG_W, 128: image width in pixels; must be a multiple of ROM_DW.
- IMG_H, 128: image height in pixels.
- ROM_DW, 16: pixels per ROM word.
- PIX_W, 8: distance width; MAXD = 2^PIX_W-1.
- Derived localparams: SA_W = clog2(IMG_W*IMG_H/ROM_DW); RA_W = clog2(IMG_W*IMG_H).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- mode  in  1  0 = chessboard (8-neighbour), 1 = city-block (4-neighbour); latched on accepted start.
- busy  out  1  high from accepted start until done rises.
- done  out  1  level; high in DONE until the next accepted start.
- sti_rd  out  1  ROM read strobe.
- sti_addr  out  SA_W  ROM word address.
- sti_di  in  ROM_DW  ROM data; bit ROM_DW-1 is the leftmost pixel.
- res_rd  out  1  RAM read strobe.
- res_wr  out  1  RAM write strobe.
- res_addr  out  RA_W  RAM address = row*IMG_W + col.
- res_do  out  PIX_W  RAM write data.
- res_di  in  PIX_W  RAM read data.

## Operation
- Reset state: all outputs 0 and FSM in IDLE.
- Reset asserted mid-run: immediate return to IDLE. RAM contents are undefined; a new start reruns the whole flow.
- States: IDLE, LOAD_RD, LOAD_WR, FW_CHK, FW_EVAL, FW_NB, FW_WR, BW_CHK, BW_EVAL, BW_NB, BW_WR, DONE.
- IDLE/DONE + start -> LOAD_RD. start while busy is ignored.
- LOAD:
  - LOAD_RD issues sti_rd for word w.
  - LOAD_WR then spends ROM_DW cycles writing each bit (MSB first) as 0 or 1 to RAM address w*ROM_DW+b.
  - After the last word, go to FW_CHK at pixel (0,0).
- Forward pass, raster order row 0..IMG_H-1, col 0..IMG_W-1:
  - FW_CHK reads the centre pixel.
  - FW_EVAL: if res_di == 0, advance to the next pixel; otherwise fetch neighbours in FW_NB.
  - Neighbour sets: mode 0 uses NW, N, NE, W (k = 4); mode 1 uses N, W (k = 2).
  - FW_WR writes sat(min(neighbours)+1).
- Backward pass, reverse raster order from (IMG_H-1, IMG_W-1) down to (0,0):
  - Same flow, using neighbour sets SE, S, SW, E (mode 0) or S, E (mode 1).
  - BW_WR writes min(centre, sat(min(neighbours)+1)).
- Out-of-image neighbours read as 0. Their cycle is still spent, with res_rd deasserted.
- Arithmetic rules:
  - sat(x+1) = MAXD when x == MAXD.
  - Comparisons are unsigned, PIX_W bits wide.
  - The centre value is held in a register across the neighbour fetches.
- Only one of sti_rd, res_rd, res_wr is high in any cycle.
- After the last backward pixel, go to DONE; done = 1, busy = 0.

## Timing
- ROM and RAM reads are synchronous with 1-cycle latency: data is valid on the edge after the strobe cycle.
- Writes complete in the strobe cycle.
- Per-pixel pass cycle budget:
  - Background pixel: exactly 2 cycles (CHK, EVAL).
  - Object pixel: exactly k+3 cycles.
    - CHK: centre read.
    - EVAL: issue neighbour 0.
    - k-1 cycles: capture neighbour j-1, issue neighbour j.
    - 1 cycle: capture the last neighbour.
    - WR.
- Load cost: L = (IMG_W*IMG_H/ROM_DW)*(1+ROM_DW) cycles.
- done rises exactly L+F+B+1 cycles after the start edge, where F and B are the summed pass budgets.
- Address wrap: column rollover increments the row. A row or column counter reaching its end terminates the pass; there is no modulo wrap into row 0.

## Test plan
- Default parameters, mode 0, all-zero ROM:
  - RAM ends all 0.
  - done rises 17408+32768+32768+1 = 82945 cycles after start.
  - No res_wr occurs during either pass.
- Single object pixel at (64,64), mode 0:
  - RAM(64*128+64) = 1.
  - All other addresses = 0.
- 5x5 object block centred at (10,10):
  - Mode 0: centre = 3, ring = 2, outer ring = 1.
  - Mode 1: corners = 1, centre = 3, edge midpoints = 1, and (10,9) = 2.
- PIX_W = 2, 9x9 block:
  - Centre value saturates at 3 instead of reaching 5.
  - No wrap to 0.
- IMG_W = 16, IMG_H = 8, ROM_DW = 8, random image:
  - RAM matches the golden two-pass model for both modes.
  - sti_addr never exceeds 15.
- Reset pulsed during the forward pass, then start with mode 1:
  - busy/done/strobes are 0 within the reset.
  - Final RAM matches the model.
  - start pulses while busy are ignored.
